// File: rtl/proc_pkg.sv
// proc_pkg: fetch FSM state type and instruction-fetch constants shared by the fetch unit files
package proc_pkg;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_WAIT_DISCARD,
        S_HALT
    } fetch_state_t;
    localparam logic [4:0]  HALT_OP = 5'b00000;
    localparam logic [15:0] PC_INC  = 16'd2;
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: instruction-memory, redirect, decode and status signals of the fetch unit
interface ifetch_unit_if;
    logic        imem_rd_en;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        redirect_en;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pc_next;
    logic        halted;
    logic        err;
    modport master (
        output imem_rd_en, imem_addr, instr_valid, instr, instr_pc, instr_pc_next, halted, err,
        input  imem_valid, imem_rdata, redirect_en, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_rd_en, imem_addr, instr_valid, instr, instr_pc, instr_pc_next, halted, err,
        output imem_valid, imem_rdata, redirect_en, redirect_pc, instr_ready
    );
endinterface

// File: rtl/ifetch_unit_fifo.sv
// ifetch_fifo: instruction queue with push/pop/flush and a head taken straight from storage registers
module ifetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     head_valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;
    assign head_valid = count != '0;
    assign do_pop     = pop && head_valid;
    assign do_push    = push && (count != FULL || do_pop);
    assign head       = mem[rd_ptr];
    // storage and pointers; flush empties the queue but leaves stored words alone
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: single-outstanding instruction fetcher with redirect/discard and a decode queue;
// define IFETCH_HALT_DETECT_EN to stop issuing after a HALT opcode is fetched
module ifetch_unit
    import proc_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 2
) (
    input logic          clk,
    input logic          rst,
    ifetch_unit_if.master bus
);
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);
    fetch_state_t  state;
    fetch_state_t  state_nx;
    logic [15:0]   pc;
    logic [15:0]   req_addr;
    logic          err_q;
    logic          issue;
    logic          outstanding;
    logic          push;
    logic          halt_word;
    logic [31:0]   head;
    logic [CW-1:0] count;
    assign outstanding = state == S_WAIT || state == S_WAIT_DISCARD;
    assign issue       = !rst && state == S_IDLE && !bus.redirect_en && count < QFULL;
    assign push        = bus.imem_valid && state == S_WAIT && !bus.redirect_en;
`ifdef IFETCH_HALT_DETECT_EN
    assign halt_word  = bus.imem_rdata[15:11] == HALT_OP;
    assign bus.halted = state == S_HALT;
`else
    assign halt_word  = 1'b0;
    assign bus.halted = 1'b0;
`endif
    // next state: redirect dominates; a response still in flight at redirect time gets dropped
    always_comb begin
        state_nx = state;
        if (bus.redirect_en)
            state_nx = (outstanding && !bus.imem_valid) ? S_WAIT_DISCARD : S_IDLE;
        else if (issue)
            state_nx = S_WAIT;
        else if (outstanding && bus.imem_valid)
            state_nx = (state == S_WAIT && halt_word) ? S_HALT : S_IDLE;
    end
    // state, fetch PC, address of the outstanding request, and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            err_q    <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= bus.redirect_en ? bus.redirect_pc : issue ? pc + PC_INC : pc;
            if (issue) req_addr <= pc;
            if ((bus.imem_valid && !outstanding) || (bus.redirect_en && bus.redirect_pc[0]))
                err_q <= 1'b1;
        end
    end
    ifetch_fifo #(.DEPTH(QDEPTH), .WIDTH(32)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (bus.instr_ready),
        .flush      (bus.redirect_en),
        .din        ({bus.imem_rdata, req_addr}),
        .head       (head),
        .head_valid (bus.instr_valid),
        .count      (count)
    );
    assign bus.imem_rd_en    = issue;
    assign bus.imem_addr     = pc;
    assign bus.instr         = head[31:16];
    assign bus.instr_pc      = head[15:0];
    assign bus.instr_pc_next = head[15:0] + PC_INC;
    assign bus.err           = err_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: randomized fetch bench with a program-order scoreboard and a latency-controlled memory model
module tb_ifetch_unit;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          QDEPTH   = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    ifetch_unit_if bus_if();
    ifetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (.clk(clk), .rst(rst), .bus(bus_if));
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] sb[$];
    logic [15:0] exp_fetch_pc = RESET_PC;
    bit          halt_on = 1'b0;
    logic [15:0] halt_addr = 16'h0006;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          mem_off = 1'b0;
    int          req_cnt = 0;
    int          pop_cnt = 0;
    logic [15:0] last_pc = 16'h0000;
    bit          pend = 1'b0;
    int          cd = 0;
    logic [15:0] paddr = 16'h0000;

    // program image: every address holds a distinct non-HALT word unless a HALT is planted
    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] w;
        w = ((a * 16'h9E37) ^ 16'h1234) | 16'h8000;
        return (halt_on && a == halt_addr) ? 16'h0000 : w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // expected decode stream is simply program order from the latest start PC
    task automatic sb_restart(input logic [15:0] p);
        logic [15:0] a;
        a = p;
        sb.delete();
        for (int i = 0; i < 256; i++) begin
            sb.push_back({word_at(a), a});
            a = a + 16'd2;
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state();
        chk("rst_rd_en", 32'(bus_if.imem_rd_en), 0);
        chk("rst_addr", 32'(bus_if.imem_addr), 32'(RESET_PC));
        chk("rst_instr_valid", 32'(bus_if.instr_valid), 0);
        chk("rst_instr", 32'(bus_if.instr), 0);
        chk("rst_instr_pc", 32'(bus_if.instr_pc), 0);
        chk("rst_instr_pc_next", 32'(bus_if.instr_pc_next), 2);
        chk("rst_halted", 32'(bus_if.halted), 0);
        chk("rst_err", 32'(bus_if.err), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_if.redirect_en = 1'b0;
        bus_if.instr_ready = 1'b0;
        cyc(2);
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_restart(RESET_PC);
        exp_fetch_pc = RESET_PC;
        req_cnt = 0;
        pop_cnt = 0;
    endtask

    task automatic do_redirect(input logic [15:0] p);
        bus_if.redirect_en = 1'b1;
        bus_if.redirect_pc = p;
        bus_if.instr_ready = 1'b0;
        sb_restart(p);
        exp_fetch_pc = p;
        cyc(1);
        bus_if.redirect_en = 1'b0;
    endtask

    task automatic wait_req(input logic [15:0] a, input bit any_addr);
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_if.imem_rd_en && (any_addr || bus_if.imem_addr == a)) break;
        end
        if (i == 60) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_req: no request to %h within 60 cycles", a);
        end
    endtask

    // memory model: one response per request after the chosen latency; checks issue order
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!mem_off) begin
                bus_if.imem_valid = 1'b0;
                if (pend) begin
                    cd--;
                    if (cd == 0) begin
                        bus_if.imem_valid = 1'b1;
                        bus_if.imem_rdata = word_at(paddr);
                        pend = 1'b0;
                    end
                end
            end
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
                exp_fetch_pc = RESET_PC;
            end else if (bus_if.imem_rd_en) begin
                req_cnt++;
                if (!mem_off) begin
                    chk("one_outstanding", 32'(pend), 0);
                    chk("fetch_addr", 32'(bus_if.imem_addr), 32'(exp_fetch_pc));
                    exp_fetch_pc = exp_fetch_pc + 16'd2;
                    pend = 1'b1;
                    paddr = bus_if.imem_addr;
                    cd = rand_lat ? int'($urandom_range(1, 4)) : lat;
                end
            end
        end
    end

    // monitor: compares every accepted head against the scoreboard and checks stall stability
    initial begin
        bit          stall;
        logic [31:0] held;
        logic [31:0] e;
        logic [15:0] nx;
        stall = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (stall) begin
                chk("hold_valid", 32'(bus_if.instr_valid), 1);
                chk("hold_head", {bus_if.instr, bus_if.instr_pc}, held);
            end
            stall = !rst && bus_if.instr_valid && !bus_if.instr_ready && !bus_if.redirect_en;
            held = {bus_if.instr, bus_if.instr_pc};
            if (!rst && bus_if.instr_valid && bus_if.instr_ready && !bus_if.redirect_en) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_empty: got pc %h with nothing expected", bus_if.instr_pc);
                end else begin
                    e = sb.pop_front();
                    nx = e[15:0] + 16'd2;
                    chk("instr", 32'(bus_if.instr), 32'(e[31:16]));
                    chk("instr_pc", 32'(bus_if.instr_pc), 32'(e[15:0]));
                    chk("instr_pc_next", 32'(bus_if.instr_pc_next), 32'(nx));
                    pop_cnt++;
                    last_pc = bus_if.instr_pc;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int since;
        bus_if.imem_valid = 1'b0;
        bus_if.imem_rdata = 16'h0000;
        bus_if.redirect_en = 1'b0;
        bus_if.redirect_pc = 16'h0000;
        bus_if.instr_ready = 1'b0;

        // first request right after reset, then back-pressure with a full queue
        lat = 1;
        do_reset();
        @(negedge clk);
        chk("first_req", 32'(bus_if.imem_rd_en), 1);
        chk("first_addr", 32'(bus_if.imem_addr), 32'(RESET_PC));
        cyc(10);
        @(negedge clk);
        chk("stall_req_cnt", 32'(req_cnt), 2);
        chk("stall_rd_en", 32'(bus_if.imem_rd_en), 0);
        chk("stall_head_pc", 32'(bus_if.instr_pc), 32'(RESET_PC));
        @(posedge clk);
        #1;
        bus_if.instr_ready = 1'b1;
        cyc(20);
        chk("stream_progress", 32'(pop_cnt >= 8), 1);

        // redirect while a latency-3 request to 0004 is outstanding
        lat = 3;
        do_reset();
        bus_if.instr_ready = 1'b1;
        wait_req(16'h0004, 1'b0);
        @(posedge clk);
        #1;
        do_redirect(16'h0100);
        bus_if.instr_ready = 1'b1;
        @(negedge clk);
        chk("discard_wait", 32'(bus_if.imem_rd_en), 0);
        @(negedge clk);
        chk("discard_resp", 32'(bus_if.imem_valid), 1);
        chk("discard_no_issue", 32'(bus_if.imem_rd_en), 0);
        @(negedge clk);
        chk("redirect_issue", 32'(bus_if.imem_rd_en), 1);
        chk("redirect_addr", 32'(bus_if.imem_addr), 32'h0100);
        cyc(30);
        chk("redirect_progress", 32'(pop_cnt >= 4), 1);

        // redirect in the same cycle as the response
        lat = 2;
        do_reset();
        wait_req(16'h0000, 1'b1);
        cyc(2);
        bus_if.redirect_en = 1'b1;
        bus_if.redirect_pc = 16'h0040;
        sb_restart(16'h0040);
        exp_fetch_pc = 16'h0040;
        @(negedge clk);
        chk("coincide_valid", 32'(bus_if.imem_valid), 1);
        @(posedge clk);
        #1;
        bus_if.redirect_en = 1'b0;
        @(negedge clk);
        chk("coincide_no_push", 32'(bus_if.instr_valid), 0);
        chk("coincide_issue", 32'(bus_if.imem_rd_en), 1);
        chk("coincide_addr", 32'(bus_if.imem_addr), 32'h0040);
        @(posedge clk);
        #1;
        bus_if.instr_ready = 1'b1;
        cyc(15);
        chk("coincide_progress", 32'(pop_cnt >= 2), 1);

        // HALT opcode at 0006
        lat = 1;
        halt_on = 1'b1;
        do_reset();
        bus_if.instr_ready = 1'b1;
        cyc(20);
        @(negedge clk);
`ifdef IFETCH_HALT_DETECT_EN
        chk("halt_set", 32'(bus_if.halted), 1);
        chk("halt_req_cnt", 32'(req_cnt), 4);
        chk("halt_rd_en", 32'(bus_if.imem_rd_en), 0);
        chk("halt_last_pc", 32'(last_pc), 32'h0006);
        @(posedge clk);
        #1;
        do_redirect(16'h0010);
        @(negedge clk);
        chk("halt_cleared", 32'(bus_if.halted), 0);
`else
        chk("halt_ignored", 32'(bus_if.halted), 0);
        chk("halt_passed", 32'(last_pc > 16'h0006), 1);
`endif
        cyc(4);
        halt_on = 1'b0;

        // randomized traffic with random latency, back-pressure and redirects
        rand_lat = 1'b1;
        do_reset();
        since = 0;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 39) == 0 || since >= 150) begin
                do_redirect($urandom_range(0, 7) == 0 ? 16'hFFF8 : (16'($urandom) & 16'hFFFE));
                since = 0;
            end else begin
                bus_if.instr_ready = $urandom_range(0, 3) != 0;
                cyc(1);
                since++;
            end
        end
        chk("rand_err", 32'(bus_if.err), 0);
        chk("rand_progress", 32'(pop_cnt > 300), 1);
        rand_lat = 1'b0;

        // odd redirect target sets err and still loads the PC
        lat = 1;
        do_reset();
        cyc(3);
        chk("err_clear", 32'(bus_if.err), 0);
        do_redirect(16'h0101);
        @(negedge clk);
        chk("err_odd", 32'(bus_if.err), 1);
        chk("odd_issue_addr", 32'(bus_if.imem_addr), 32'h0101);
        cyc(5);
        chk("err_sticky", 32'(bus_if.err), 1);

        // spurious response while idle (issue held off by a redirect)
        rst = 1'b1;
        bus_if.redirect_en = 1'b1;
        bus_if.redirect_pc = 16'h0200;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        mem_off = 1'b1;
        bus_if.imem_valid = 1'b1;
        cyc(1);
        bus_if.imem_valid = 1'b0;
        @(negedge clk);
        chk("err_spurious", 32'(bus_if.err), 1);
        @(posedge clk);
        #1;
        bus_if.redirect_en = 1'b0;
        sb_restart(16'h0200);
        exp_fetch_pc = 16'h0200;
        mem_off = 1'b0;
        cyc(5);
        chk("err_spurious_sticky", 32'(bus_if.err), 1);

        // reset abandons an outstanding request; its late response is an error
        do_reset();
        mem_off = 1'b1;
        wait_req(16'h0000, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus_if.redirect_en = 1'b1;
        bus_if.redirect_pc = 16'h0300;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        bus_if.imem_valid = 1'b1;
        cyc(1);
        bus_if.imem_valid = 1'b0;
        @(negedge clk);
        chk("err_abandoned", 32'(bus_if.err), 1);
        @(posedge clk);
        #1;
        bus_if.redirect_en = 1'b0;
        sb_restart(16'h0300);
        exp_fetch_pc = 16'h0300;
        mem_off = 1'b0;
        cyc(5);

        do_reset();
        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
